counter_mod_k_ctrl: RTL and testbench
=====================================

COUNTER_MOD_K_CTRL -- requirements
Module: counter_mod_k_ctrl

Interface
REQ-001 Parameter N, default 8: width of modulus, count and load value.
REQ-002 Parameter M, default 8: width of wrap counter.
REQ-003 i_clk  in  1  single clock; all state updates on its rising edge.
REQ-004 i_reset_n  in  1  asynchronous, active-low reset.
REQ-005 i_start  in  1  capture i_k and i_mode, then enter RUN.
REQ-006 i_stop  in  1  abort and return to IDLE.
REQ-007 i_en  in  1  count enable in RUN.
REQ-008 i_dir  in  1  0 = up, 1 = down; sampled every enabled cycle.
REQ-009 i_mode  in  1  0 = continuous, 1 = one-shot; captured on start.
REQ-010 i_load  in  1  synchronous load of i_load_val in RUN.
REQ-011 i_k  in  N  modulus; 0 means 2^N.
REQ-012 i_load_val  in  N  value for i_load.
REQ-013 o_count  out  N  current count, registered.
REQ-014 o_tc  out  1  one-cycle terminal-count (wrap) pulse, registered.
REQ-015 o_wraps  out  M  number of wraps since start; saturates at 2^M-1.
REQ-016 o_busy  out  1  high in RUN.
REQ-017 o_done  out  1  high in DONE.

Function
REQ-018 States: IDLE, RUN, DONE. Input priority in every state: i_stop > i_start > i_load > i_en.
REQ-019 IDLE behaviour:
  - o_count holds 0.
  - i_start: k_reg <= i_k, mode_reg <= i_mode, o_wraps <= 0, go to RUN.
  - Initial count: 0 if i_dir=0; k_reg-1 if i_dir=1.
REQ-020 RUN, i_en=1, up:
  - count < k_reg-1: count+1.
  - count = k_reg-1: count <= 0, o_tc=1 next cycle (wrap).
REQ-021 RUN, i_en=1, down:
  - count > 0: count-1.
  - count = 0: count <= k_reg-1, o_tc=1 next cycle (wrap).
REQ-022 RUN, i_en=0: count, o_wraps and state hold; o_tc=0.
REQ-023 Continuous-mode wrap: o_wraps increments by 1, saturating at 2^M-1; state stays RUN.
REQ-024 One-shot-mode wrap:
  - count holds its pre-wrap value (k_reg-1 up, 0 down).
  - o_tc pulses; o_wraps becomes 1; go to DONE.
REQ-025 i_load in RUN:
  - count <= i_load_val if i_load_val < k_reg, else k_reg-1.
  - No o_tc and no o_wraps change.
REQ-026 DONE: count and o_wraps hold; i_en and i_load ignored; i_start restarts as from IDLE; i_stop goes to IDLE.
REQ-027 i_start in RUN or DONE restarts per REQ-019 in the same cycle; o_wraps is cleared.
REQ-028 i_stop in any state: count <= 0, go to IDLE; o_wraps holds its last value.
REQ-029 k_reg=0 means modulus 2^N: terminal values are 2^N-1 and 0; arithmetic wraps naturally at N bits.
REQ-030 k_reg=1: count stays 0; every enabled cycle is a wrap (o_tc high continuously in continuous mode).
REQ-031 Changes on i_k outside a start have no effect on the running modulus.
REQ-032 Changing i_dir mid-run is legal; terminal detection uses the direction sampled in the current cycle.
REQ-033 o_tc is high for exactly one cycle per wrap and low in IDLE and DONE except on the entry cycle of DONE.

Reset
REQ-034 i_reset_n=0 forces immediately, independent of i_clk:
  - state IDLE, o_count=0, o_tc=0, o_wraps=0, o_busy=0, o_done=0, k_reg=0, mode_reg=0.
REQ-035 Reset mid-RUN abandons the operation; no o_tc is generated.
REQ-036 After reset deassertion, the first transition requires i_start.

Verification
REQ-037 N=8, k=5, continuous, up, i_en=1 for 12 cycles -> count 0,1,2,3,4,0,1,2,3,4,0,1; o_tc after each 4->0 wrap; o_wraps=2.
REQ-038 k=4, one-shot, down -> count 3,2,1,0; o_tc one cycle; DONE with count=0, o_wraps=1, o_done=1; i_en ignored afterwards.
REQ-039 k=0, up, load 254, then 2 enables -> count 255, then 0 with o_tc=1.
REQ-040 k=6, i_load_val=9 -> count=5; next up enable -> 0, o_tc=1.
REQ-041 Simultaneous i_stop+i_start+i_en in RUN -> IDLE, count=0; i_start with i_load -> restart values, load ignored.
REQ-042 M=2, k=1, continuous, 5 enables -> o_wraps saturates at 3; reset pulse mid-run -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/counter_mod_k_ctrl.sv
// Modulo-k up/down counter with IDLE/RUN/DONE control.
// Counts modulo a captured modulus k (k = 0 selects 2^N). In continuous mode
// it wraps and tallies wraps (saturating). In one-shot mode the first wrap
// freezes the count and parks the controller in DONE.
module counter_mod_k_ctrl #(
  parameter int N = 8,
  parameter int M = 8
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_start,
  input  logic         i_stop,
  input  logic         i_en,
  input  logic         i_dir,
  input  logic         i_mode,
  input  logic         i_load,
  input  logic [N-1:0] i_k,
  input  logic [N-1:0] i_load_val,
  output logic [N-1:0] o_count,
  output logic         o_tc,
  output logic [M-1:0] o_wraps,
  output logic         o_busy,
  output logic         o_done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [N-1:0] ONE_N = N'(1);
  localparam logic [M-1:0] ONE_M = M'(1);

  state_t       r_state;
  logic [N-1:0] r_k;
  logic         r_mode;
  logic [N-1:0] r_count;
  logic         r_tc;
  logic [M-1:0] r_wraps;
  logic         r_busy;
  logic         r_done;

  // Highest legal count for the running modulus. k = 0 gives all ones,
  // which is exactly the 2^N case; k = 1 gives 0, so the count never moves.
  logic [N-1:0] w_k_last;
  // Highest legal count for the modulus presented with a start.
  logic [N-1:0] w_start_last;
  // Count value a start begins from: bottom when counting up, top when down.
  logic [N-1:0] w_start_count;
  // Terminal value reached in the direction sampled this cycle.
  logic         w_term;
  // Value the count jumps to on a continuous-mode wrap.
  logic [N-1:0] w_wrap_count;
  // Ordinary one-step move in the current direction.
  logic [N-1:0] w_step_count;
  // Load value clamped into the legal range; k = 0 accepts every value.
  logic [N-1:0] w_load_clamped;

  // Saturating increment so the wrap tally sticks at its maximum.
  function automatic logic [M-1:0] sat_inc(input logic [M-1:0] v);
    if (&v) begin
      return v;
    end
    return v + ONE_M;
  endfunction

  // Clamp a load request to the top of the modulus range.
  function automatic logic [N-1:0] clamp_load(input logic [N-1:0] val,
                                              input logic [N-1:0] k,
                                              input logic [N-1:0] k_last);
    if ((k == '0) || (val < k)) begin
      return val;
    end
    return k_last;
  endfunction

  assign w_k_last       = r_k - ONE_N;
  assign w_start_last   = i_k - ONE_N;
  assign w_start_count  = i_dir ? w_start_last : '0;
  assign w_term         = i_dir ? (r_count == '0) : (r_count == w_k_last);
  assign w_wrap_count   = i_dir ? w_k_last : '0;
  assign w_step_count   = i_dir ? (r_count - ONE_N) : (r_count + ONE_N);
  assign w_load_clamped = clamp_load(i_load_val, r_k, w_k_last);

  // Controller and datapath: stop beats start beats load beats enable.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
      r_k     <= '0;
      r_mode  <= 1'b0;
      r_count <= '0;
      r_tc    <= 1'b0;
      r_wraps <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      // The wrap pulse lasts one cycle unless a wrap happens again below.
      r_tc <= 1'b0;
      if (i_stop) begin
        // Abort from anywhere; the wrap tally is kept for inspection.
        r_state <= ST_IDLE;
        r_count <= '0;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
      end else if (i_start) begin
        // Start (or restart) captures the modulus and mode afresh.
        r_state <= ST_RUN;
        r_k     <= i_k;
        r_mode  <= i_mode;
        r_count <= w_start_count;
        r_wraps <= '0;
        r_busy  <= 1'b1;
        r_done  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_count <= '0;
          end
          ST_RUN: begin
            if (i_load) begin
              r_count <= w_load_clamped;
            end else if (i_en) begin
              if (w_term) begin
                r_tc <= 1'b1;
                if (r_mode) begin
                  // One-shot: freeze on the terminal value and finish.
                  r_state <= ST_DONE;
                  r_wraps <= ONE_M;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                end else begin
                  r_count <= w_wrap_count;
                  r_wraps <= sat_inc(r_wraps);
                end
              end else begin
                r_count <= w_step_count;
              end
            end
          end
          ST_DONE: begin
            // Count and tally hold; only start or stop leave this state.
          end
          default: begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_count = r_count;
  assign o_tc    = r_tc;
  assign o_wraps = r_wraps;
  assign o_busy  = r_busy;
  assign o_done  = r_done;

endmodule

// File: tb/tb_counter_mod_k_ctrl.sv
// Scoreboard bench for counter_mod_k_ctrl (N = 8, M = 2).
// Stimulus pushes hand-computed post-edge expectations; a monitor pops and
// compares one entry after every rising edge.
module tb_counter_mod_k_ctrl;

  logic       clk = 1'b0;
  logic       i_reset_n;
  logic       i_start, i_stop, i_en, i_dir, i_mode, i_load;
  logic [7:0] i_k, i_load_val;
  logic [7:0] o_count;
  logic       o_tc;
  logic [1:0] o_wraps;
  logic       o_busy, o_done;

  typedef struct packed {
    logic [7:0] count;
    logic       tc;
    logic [1:0] wraps;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  counter_mod_k_ctrl #(.N(8), .M(2)) dut (
    .i_clk      (clk),
    .i_reset_n  (i_reset_n),
    .i_start    (i_start),
    .i_stop     (i_stop),
    .i_en       (i_en),
    .i_dir      (i_dir),
    .i_mode     (i_mode),
    .i_load     (i_load),
    .i_k        (i_k),
    .i_load_val (i_load_val),
    .o_count    (o_count),
    .o_tc       (o_tc),
    .o_wraps    (o_wraps),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".count"}, int'(o_count), int'(e.count));
    chk({tag, ".tc"},    int'(o_tc),    int'(e.tc));
    chk({tag, ".wraps"}, int'(o_wraps), int'(e.wraps));
    chk({tag, ".busy"},  int'(o_busy),  int'(e.busy));
    chk({tag, ".done"},  int'(o_done),  int'(e.done));
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic step(input logic st, input logic sp, input logic en,
                      input logic dir, input logic mode, input logic ld,
                      input logic [7:0] k, input logic [7:0] lv,
                      input logic [7:0] ec, input logic etc,
                      input logic [1:0] ew, input logic eb, input logic ed);
    exp_t e;
    @(negedge clk);
    i_start = st; i_stop = sp; i_en = en; i_dir = dir;
    i_mode = mode; i_load = ld; i_k = k; i_load_val = lv;
    e.count = ec; e.tc = etc; e.wraps = ew; e.busy = eb; e.done = ed;
    q.push_back(e);
  endtask

  // Monitor: every rising edge presents a new output word.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk_all("cyc", e);
      end
    end
  end

  // Watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t z;
    z = '0;
    i_reset_n = 1'b0;
    i_start = 0; i_stop = 0; i_en = 0; i_dir = 0; i_mode = 0; i_load = 0;
    i_k = 8'd0; i_load_val = 8'd0;
    #3;
    chk_all("reset", z);
    @(negedge clk);
    i_reset_n = 1'b1;

    // No start yet: enable alone does nothing.
    step(0,0,1,0,0,0, 8'd5, 8'd0,  8'd0, 0, 2'd0, 0, 0);

    // k=5 continuous up, 12 enables.
    step(1,0,0,0,0,0, 8'd5, 8'd0,  8'd0, 0, 2'd0, 1, 0);
    for (int i = 1; i <= 12; i++)
      step(0,0,1,0,0,0, 8'd5, 8'd0, 8'(i % 5), (i % 5) == 0, 2'(i / 5), 1, 0);
    step(0,0,0,0,0,0, 8'd5, 8'd0,  8'd2, 0, 2'd2, 1, 0);

    // k=4 one-shot down.
    step(1,0,0,1,1,0, 8'd4, 8'd0,  8'd3, 0, 2'd0, 1, 0);
    step(0,0,1,1,0,0, 8'd4, 8'd0,  8'd2, 0, 2'd0, 1, 0);
    step(0,0,1,1,0,0, 8'd4, 8'd0,  8'd1, 0, 2'd0, 1, 0);
    step(0,0,1,1,0,0, 8'd4, 8'd0,  8'd0, 0, 2'd0, 1, 0);
    step(0,0,1,1,0,0, 8'd4, 8'd0,  8'd0, 1, 2'd1, 0, 1);
    step(0,0,1,1,0,0, 8'd4, 8'd0,  8'd0, 0, 2'd1, 0, 1);
    step(0,0,0,0,0,1, 8'd4, 8'd2,  8'd0, 0, 2'd1, 0, 1);
    step(0,1,0,0,0,0, 8'd4, 8'd0,  8'd0, 0, 2'd1, 0, 0);

    // k=0 (modulus 256): load 254, then two up enables.
    step(1,0,0,0,0,0, 8'd0, 8'd0,   8'd0,   0, 2'd0, 1, 0);
    step(0,0,0,0,0,1, 8'd0, 8'd254, 8'd254, 0, 2'd0, 1, 0);
    step(0,0,1,0,0,0, 8'd0, 8'd0,   8'd255, 0, 2'd0, 1, 0);
    step(0,0,1,0,0,0, 8'd0, 8'd0,   8'd0,   1, 2'd1, 1, 0);

    // k=6: load 9 clamps to 5, then wraps with direction changes.
    step(1,0,0,0,0,0, 8'd6, 8'd0,  8'd0, 0, 2'd0, 1, 0);
    step(0,0,0,0,0,1, 8'd6, 8'd9,  8'd5, 0, 2'd0, 1, 0);
    step(0,0,1,0,0,0, 8'd6, 8'd0,  8'd0, 1, 2'd1, 1, 0);
    step(0,0,1,1,0,0, 8'd6, 8'd0,  8'd5, 1, 2'd2, 1, 0);
    step(0,0,1,0,0,0, 8'd6, 8'd0,  8'd0, 1, 2'd3, 1, 0);
    step(0,0,1,0,0,0, 8'd6, 8'd0,  8'd1, 0, 2'd3, 1, 0);

    // Priority: stop wins over start and enable; start wins over load.
    step(1,1,1,0,0,0, 8'd9, 8'd0,  8'd0, 0, 2'd3, 0, 0);
    step(1,0,0,1,0,0, 8'd7, 8'd0,  8'd6, 0, 2'd0, 1, 0);
    step(1,0,1,0,0,1, 8'd3, 8'd1,  8'd0, 0, 2'd0, 1, 0);
    // i_k changes without a start leave the running modulus at 3.
    step(0,0,1,0,0,0, 8'd2, 8'd0,  8'd1, 0, 2'd0, 1, 0);
    step(0,0,1,0,0,0, 8'd2, 8'd0,  8'd2, 0, 2'd0, 1, 0);
    step(0,0,1,0,0,0, 8'd2, 8'd0,  8'd0, 1, 2'd1, 1, 0);

    // k=1 continuous: every enable wraps; tally saturates at 3.
    step(1,0,0,0,0,0, 8'd1, 8'd0,  8'd0, 0, 2'd0, 1, 0);
    for (int i = 1; i <= 5; i++)
      step(0,0,1,0,0,0, 8'd1, 8'd0, 8'd0, 1, (i > 3) ? 2'd3 : 2'(i), 1, 0);

    // Asynchronous reset between edges while o_tc is high.
    @(negedge clk);
    #2;
    i_reset_n = 1'b0;
    #1;
    chk_all("async_rst", z);
    @(negedge clk);
    chk_all("rst_hold", z);
    i_reset_n = 1'b1;
    // After reset an enable without start stays idle.
    step(0,0,1,0,0,0, 8'd1, 8'd0,  8'd0, 0, 2'd0, 0, 0);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
